// File: rtl/ibex_icache_mem_pkg.sv
// Shared types and constants for the icache fetch-bus memory responder.
package ibex_icache_mem_pkg;

  localparam int unsigned EntryAddrW  = 32;
  localparam int unsigned EntryDelayW = 4;
  localparam logic [31:0] SeedDefault = 32'hA5A5_0000;

  // One granted fetch waiting for its response.
  typedef struct packed {
    logic [EntryAddrW-1:0]  addr;
    logic                   err;
    logic [EntryDelayW-1:0] delay;
  } mem_entry_t;

endpackage

// File: rtl/ibex_icache_mem_fifo.sv
// In-order outstanding-request buffer whose entries age by one cycle per clock.
module ibex_icache_mem_fifo
  import ibex_icache_mem_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter int unsigned DelayW = EntryDelayW,
  parameter type         entry_t = mem_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     push_entry_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic                       head_ready_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [Depth-1:0]  valid_c;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r = e;
    if (r.delay != '0) r.delay = r.delay - DelayW'(1);
    return r;
  endfunction

  always_comb begin
    valid_c = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      valid_c[i] = ((i + Depth - 32'(rd_ptr_q)) % Depth) < 32'(count_q);
    end
  end

  // A pushed entry already counts its grant cycle, so it is stored one cycle older.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_c[i]) mem_q[i] <= age(mem_q[i]);
    end
    if (push_i) mem_q[wr_ptr_q] <= age(push_entry_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // An empty buffer presents the incoming entry so zero-delay fetches answer next cycle.
  assign head_o       = (count_q == '0) ? push_entry_i : mem_q[rd_ptr_q];
  assign head_ready_o = (count_q != '0) ? (mem_q[rd_ptr_q].delay == '0)
                                        : (push_i && (push_entry_i.delay == '0));
  assign count_o      = count_q;

endmodule

// File: rtl/ibex_icache_mem_responder.sv
// Memory-side responder for the icache fetch bus: grant/PMP gating, in-order
// delayed responses with error injection, flush and response counting.
module ibex_icache_mem_responder
  import ibex_icache_mem_pkg::*;
#(
  parameter int unsigned      AddrW  = 32,
  parameter int unsigned      DataW  = 32,
  parameter int unsigned      Depth  = 4,
  parameter int unsigned      DelayW = 4,
  parameter logic [DataW-1:0] Seed   = DataW'(SeedDefault)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [AddrW-1:0]           addr_i,
  output logic                       gnt_o,
  output logic                       pmp_err_o,
  output logic                       rvalid_o,
  output logic [DataW-1:0]           rdata_o,
  output logic                       err_o,
  input  logic                       gnt_en_i,
  input  logic                       pmp_fault_i,
  input  logic                       err_inject_i,
  input  logic [DelayW-1:0]          delay_i,
  input  logic                       rsp_en_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic [31:0]                rsp_cnt_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [AddrW-1:0]  addr;
    logic              err;
    logic [DelayW-1:0] delay;
  } entry_t;

  entry_t          push_entry, head;
  logic            head_ready, pop;
  logic [CntW-1:0] count;
  logic            unused_head_delay;

  assign pmp_err_o  = req_i & pmp_fault_i;
  assign gnt_o      = req_i & gnt_en_i & ~pmp_fault_i & ~flush_i & (count < CntW'(Depth));
  assign pop        = head_ready & rsp_en_i & ~flush_i;
  assign push_entry = '{addr: addr_i, err: err_inject_i, delay: delay_i};

  ibex_icache_mem_fifo #(
    .Depth  (Depth),
    .DelayW (DelayW),
    .entry_t(entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (gnt_o),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .head_ready_o(head_ready),
    .count_o     (count)
  );

  // Response beat; rdata keeps its last value between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      rsp_cnt_o <= '0;
    end else begin
      rvalid_o <= pop;
      err_o    <= pop & head.err;
      if (pop) begin
        rdata_o   <= DataW'(head.addr) ^ Seed;
        rsp_cnt_o <= rsp_cnt_o + 32'd1;
      end
    end
  end

  assign outstanding_o     = count;
  assign unused_head_delay = ^head.delay;

endmodule

// File: tb/tb_ibex_icache_mem_responder.sv
// Randomized bench for ibex_icache_mem_responder against a timestamp-based queue model.
module tb_ibex_icache_mem_responder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        gnt_o, pmp_err_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        gnt_en_i = 1'b0, pmp_fault_i = 1'b0, err_inject_i = 1'b0;
  logic [3:0]  delay_i = '0;
  logic        rsp_en_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  outstanding_o;
  logic [31:0] rsp_cnt_o;

  always #5 clk_i = ~clk_i;

  ibex_icache_mem_responder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .pmp_err_o    (pmp_err_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .gnt_en_i     (gnt_en_i),
    .pmp_fault_i  (pmp_fault_i),
    .err_inject_i (err_inject_i),
    .delay_i      (delay_i),
    .rsp_en_i     (rsp_en_i),
    .flush_i      (flush_i),
    .outstanding_o(outstanding_o),
    .rsp_cnt_o    (rsp_cnt_o)
  );

  // Model: each pending fetch remembers the cycle from which it may answer.
  typedef struct {
    logic [31:0] addr;
    logic        err;
    int unsigned ready;
  } req_t;

  req_t        mq[$];
  int unsigned now = 0;
  logic        exp_rvalid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0, exp_cnt = '0;
  int          total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rvalid", 64'(rvalid_o), 64'(exp_rvalid));
    check("err", 64'(err_o), 64'(exp_err));
    check("rdata", 64'(rdata_o), 64'(exp_rdata));
    check("outstanding", 64'(outstanding_o), 64'(mq.size()));
    check("rsp_cnt", 64'(rsp_cnt_o), 64'(exp_cnt));
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic ge, input logic pf,
                     input logic ei, input logic [3:0] d, input logic re, input logic fl);
    logic eg, nv;
    req_t m;
    req_i = r; addr_i = a; gnt_en_i = ge; pmp_fault_i = pf;
    err_inject_i = ei; delay_i = d; rsp_en_i = re; flush_i = fl;
    #1;
    eg = r & ge & ~pf & ~fl & (mq.size() < DEPTH);
    check("gnt", 64'(gnt_o), 64'(eg));
    check("pmp_err", 64'(pmp_err_o), 64'(r & pf));
    nv = 1'b0;
    if (fl) mq.delete();
    else begin
      if (eg) mq.push_back('{addr: a, err: ei, ready: now + 32'(d)});
      if (mq.size() > 0 && mq[0].ready <= now && re) begin
        m = mq.pop_front();
        nv = 1'b1;
        exp_rdata = m.addr ^ SEED;
        exp_err = m.err;
        exp_cnt++;
      end
    end
    if (!nv) exp_err = 1'b0;
    exp_rvalid = nv;
    @(posedge clk_i);
    now++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic re);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, re, 1'b0);
  endtask

  initial begin
    // Reset with a pending request must stay quiet.
    req_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_outputs();
    rst_ni = 1'b1;
    cyc(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

    // Single zero-delay fetch answers on the next cycle.
    cyc(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("rdata_1000", 64'(rdata_o), 64'h0000_0000_A5A5_1000);
    idle(1, 1'b1);

    // Fill, backpressure, drain in order, then grant resumes.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    idle(5, 1'b1);
    cyc(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Younger ready entry waits behind a slow head.
    cyc(1'b1, 32'h0000_0A00, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0B00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Error injection and PMP fault.
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Flush with three in flight and a live request.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h500 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    cyc(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    idle(8, 1'b1);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h700 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    mq.delete();
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_cnt = '0;
    check_outputs();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) != 0,
          ($urandom % 10) == 0, ($urandom % 8) == 0,
          (($urandom % 6) == 0) ? 4'($urandom) : 4'($urandom % 3),
          ($urandom % 4) != 0, ($urandom % 40) == 0);
    end
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_icache_mem_responder.md
Name: ibex_icache_mem_responder

Overview:
Synthesisable, parametrised memory-side responder for the icache instruction-fetch bus. Replaces the single-beat, testbench-driven response task with an in-order outstanding-request queue, per-request programmable latency, error injection, PMP-fault handling and flush. Sits between the DUT fetch port (req/gnt/addr → rvalid/rdata/err) and the bench's stimulus and control knobs.

Parameters:
AddrW, 32, request address width
DataW, 32, response data width (must be ≥ AddrW)
Depth, 4, maximum outstanding granted requests (≥1, power of two)
DelayW, 4, width of per-request latency field
Seed, 32'hA5A5_0000, XOR pattern for generated rdata

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  DUT request
addr_i  in  AddrW  DUT request address
gnt_o  out  1  grant (combinational)
pmp_err_o  out  1  PMP fault for current request (combinational)
rvalid_o  out  1  response valid (registered)
rdata_o  out  DataW  response data (registered)
err_o  out  1  response bus error (registered)
gnt_en_i  in  1  bench permits granting this cycle
pmp_fault_i  in  1  bench marks current request as PMP-faulting
err_inject_i  in  1  bench marks the request being granted as erroring
delay_i  in  DelayW  latency for the request being granted
rsp_en_i  in  1  bench permits issuing a response this cycle
flush_i  in  1  discard all outstanding requests
outstanding_o  out  $clog2(Depth+1)  queue occupancy
rsp_cnt_o  out  32  total responses issued (wraps)

Behaviour:
- Clock clk_i, reset rst_ni asynchronous active-low. During reset: rvalid_o=0, err_o=0, rdata_o=0, queue empty, outstanding_o=0, rsp_cnt_o=0.
- pmp_err_o = req_i & pmp_fault_i. A faulting request is never granted or queued.
- gnt_o = req_i & gnt_en_i & ~pmp_fault_i & ~flush_i & (occupancy < Depth). No bypass: a full queue does not grant, even when a pop occurs in the same cycle.
- On grant, push entry {addr_i, err_inject_i, delay_i} at the tail.
- Each cycle, every valid entry's remaining delay decrements, saturating at 0.
- Head issues when its delay == 0 and rsp_en_i. Next cycle: rvalid_o=1, rdata_o = zero-extended addr ^ Seed, err_o = entry error bit. Entry pops and rsp_cnt_o increments.
- Responses are strictly in order, at most one per cycle. A younger entry that reaches delay 0 waits for the head.
- When not issuing: rvalid_o=0, err_o=0, rdata_o holds its last value.
- Minimum latency: grant at cycle T with delay 0 gives rvalid_o at T+1, if the entry is head and rsp_en_i is high.
- Grant and pop in the same cycle: occupancy unchanged. Pointers wrap modulo Depth.
- flush_i: queue cleared at the next edge and rvalid_o=0 the cycle after. A response already registered in the flush cycle still completes. Flush has priority over push and pop.
- rsp_cnt_o wraps from 2^32−1 to 0.
- Asynchronous reset mid-operation: all state cleared immediately, outstanding requests lost.

Decomposition:
- Package ibex_icache_mem_pkg holds the entry typedef (addr, err, delay) and the default Seed constant.
- Sub-module ibex_icache_mem_fifo: circular buffer with Depth entries, per-entry decrementing delay, and head-ready output.
- The top level holds grant/PMP logic, response registers and counters.

Test Plan:
- Reset and idle: hold rst_ni=0 for 3 cycles with req_i=1 → rvalid_o=0, outstanding_o=0, rsp_cnt_o=0. After release with gnt_en_i=0 → gnt_o=0.
- Single zero-delay fetch: addr 0x0000_1000, delay 0, rsp_en_i=1 → gnt at T, rvalid_o at T+1, rdata_o=0xA5A5_1000, err_o=0.
- Fill and backpressure: 4 grants with delay 3, rsp_en_i=0 → outstanding_o=4 and 5th gnt_o=0. Raise rsp_en_i → 4 responses on consecutive cycles in grant order, then gnt resumes.
- Out-of-order readiness: grant A delay 7, then B delay 0 → B's rdata appears only after A's, 1 cycle later.
- Error and PMP: err_inject_i=1 on addr 0x40 → err_o=1 with its rvalid. pmp_fault_i=1 on addr 0x80 → pmp_err_o=1, gnt_o=0, occupancy unchanged.
- Flush mid-flight: 3 entries outstanding, flush_i pulse with req_i=1 → gnt_o=0 that cycle, outstanding_o=0 next cycle, no further rvalid_o. rsp_cnt_o holds its prior value.
